airi5c_itof_scheduler: RTL

Controller that shares one `airi5c_itof_converter` instance between two requesters: port 0 is the FPU issue stage and port 1 is the auxiliary conversion port. It arbitrates round-robin, latches operands, and drives the converter's `load`/`kill`/op/rm inputs. It captures the result and inexact flag, returns each result on a per-requester valid/ready channel, and keeps a sticky NX flag for fcsr.

---
 rtl/airi5c_itof_scheduler.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/airi5c_itof_scheduler.sv
// Round-robin scheduler sharing one int-to-float converter between two requesters.
// Optional sticky NX accumulator enabled by defining AIRI5C_ITOF_FFLAGS_EN.
module airi5c_itof_scheduler #(
    parameter int WAIT_MAX = 4
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        kill,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_signed,
    input  logic [2:0]  req0_rm,
    input  logic [31:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_signed,
    input  logic [2:0]  req1_rm,
    input  logic [31:0] req1_data,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_data,
    output logic        rsp0_nx,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_data,
    output logic        rsp1_nx,
    output logic        cvt_load,
    output logic        cvt_kill,
    output logic        cvt_op_cvtif,
    output logic        cvt_op_cvtuf,
    output logic [2:0]  cvt_rm,
    output logic [31:0] cvt_int,
    input  logic [31:0] cvt_float,
    input  logic        cvt_ie,
    input  logic        cvt_ready,
    output logic        fflags_nx,
    input  logic        fflags_clr,
    output logic        timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    localparam logic [3:0]  CNT_LAST = 4'(WAIT_MAX - 1);
    localparam logic [31:0] QNAN     = 32'h7FC00000;

    state_e      state_q;
    logic        owner_q, sgn_q, rr_q, nx_q, tmo_q;
    logic [2:0]  rm_q;
    logic [31:0] data_q, res_q;
    logic [3:0]  cnt_q;

    logic grant, accept, timeout_hit, rsp_vld, rsp_hs;

    // Lone requester always wins; contention resolved by rr_q.
    always_comb begin
        grant = rr_q;
        if (req0_valid && !req1_valid)      grant = 1'b0;
        else if (req1_valid && !req0_valid) grant = 1'b1;
    end

    assign accept      = (state_q == S_IDLE) && !kill && (req0_valid || req1_valid);
    assign req0_ready  = accept && !grant;
    assign req1_ready  = accept && grant;

    assign timeout_hit = (state_q == S_WAIT) && !cvt_ready && (cnt_q == CNT_LAST);
    assign cvt_load    = (state_q == S_ISSUE) && !kill;
    assign cvt_kill    = (kill && state_q != S_IDLE) || timeout_hit;
    assign cvt_op_cvtif = (state_q == S_ISSUE) && sgn_q;
    assign cvt_op_cvtuf = (state_q == S_ISSUE) && !sgn_q;
    assign cvt_rm      = rm_q;
    assign cvt_int     = data_q;

    assign rsp_vld     = (state_q == S_RESP) && !kill;
    assign rsp0_valid  = rsp_vld && !owner_q;
    assign rsp1_valid  = rsp_vld && owner_q;
    assign rsp_hs      = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
    assign rsp0_data   = res_q;
    assign rsp1_data   = res_q;
    assign rsp0_nx     = nx_q;
    assign rsp1_nx     = nx_q;
    assign timeout_err = tmo_q;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            sgn_q   <= 1'b0;
            rr_q    <= 1'b0;
            rm_q    <= '0;
            data_q  <= '0;
            res_q   <= '0;
            nx_q    <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else if (kill && state_q != S_IDLE) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    owner_q <= grant;
                    sgn_q   <= grant ? req1_signed : req0_signed;
                    rm_q    <= grant ? req1_rm : req0_rm;
                    data_q  <= grant ? req1_data : req0_data;
                    rr_q    <= !grant;
                    state_q <= S_ISSUE;
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cvt_ready) begin
                        res_q   <= cvt_float;
                        nx_q    <= cvt_ie;
                        state_q <= S_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        res_q   <= QNAN;
                        nx_q    <= 1'b0;
                        tmo_q   <= 1'b1;
                        state_q <= S_RESP;
                    end else begin
                        cnt_q   <= cnt_q + 4'd1;
                    end
                end
                S_RESP: if (rsp_hs) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef AIRI5C_ITOF_FFLAGS_EN
    logic fnx_q;

    // Set beats clear when both happen in one cycle.
    always_ff @(posedge clk) begin
        if (!n_reset)              fnx_q <= 1'b0;
        else if (rsp_hs && nx_q)   fnx_q <= 1'b1;
        else if (fflags_clr)       fnx_q <= 1'b0;
    end
    assign fflags_nx = fnx_q;
`else
    logic unused_fflags_clr;
    assign unused_fflags_clr = fflags_clr;
    assign fflags_nx = 1'b0;
`endif

endmodule
